icache_fetch: RTL and testbench

- Instruction-side responder to the 4-wide PC controller.
- Takes the current fetch PC and returns four consecutive instruction words, plus a per-slot miss vector in the controller's prefix-miss format.
- Direct-mapped cache built from register arrays; 16 B lines (4 words).
- Refills one line at a time from memory over a valid/ready request channel and a 4-beat response stream.

---
 rtl/icache_fetch.sv | 126 ++++++++++++
 tb/tb_icache_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Purpose: direct-mapped instruction cache returning 4 consecutive words per fetch PC plus a prefix-miss vector.
// Latency: lookup is combinational; a missing line is available 1 cycle after its last refill beat.
// Backpressure: the refill request holds until i_mem_req_ready; response beats have no backpressure.
module icache_fetch #(
  parameter  int LINES = 16,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_pc,
  input  logic         i_invalidate,
  output logic [127:0] o_inst,
  output logic [3:0]   o_cache_miss,
  output logic         o_mem_req_valid,
  input  logic         i_mem_req_ready,
  output logic [31:0]  o_mem_req_addr,
  input  logic         i_mem_resp_valid,
  input  logic [31:0]  i_mem_resp_data
);

  localparam int TAG_W = 28 - IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]       state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][4];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ridx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] rtag;
  logic [1:0]       off;
  logic [1:0]       cnt;
  logic             line_hit;
  logic             fill_beat;
  logic             last_beat;
  logic [2:0]       slot;

  // Word-select bits below the word boundary carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^i_pc[1:0];

  assign off       = i_pc[3:2];
  assign idx       = i_pc[4 +: IDX_W];
  assign tag       = i_pc[31:4+IDX_W];
  assign line_hit  = valid[idx] && (tag_arr[idx] == tag);
  assign fill_beat = (state == S_FILL) && i_mem_resp_valid;
  assign last_beat = fill_beat && (cnt == 2'd3);

  assign o_mem_req_valid = (state == S_REQ);

  // Lookup: slots past the line end always miss; everything misses while a refill is in flight.
  always_comb begin
    o_cache_miss = 4'b1111;
    o_inst       = '0;
    slot         = '0;
    if (state == S_IDLE && line_hit) begin
      for (int k = 0; k < 4; k++) begin
        slot = {1'b0, off} + 3'(k);
        if (slot <= 3'd3) begin
          o_cache_miss[k]    = 1'b0;
          o_inst[32*k +: 32] = data_arr[idx][slot[1:0]];
        end
      end
    end
  end

  // Refill control and line valid bits; invalidate overrides a line completing on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      valid          <= '0;
      cnt            <= 2'd0;
      o_mem_req_addr <= 32'd0;
      ridx           <= '0;
      rtag           <= '0;
    end else begin
      if (i_invalidate) begin
        valid <= '0;
      end else if (last_beat) begin
        valid[ridx] <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!line_hit && !i_invalidate) begin
            ridx           <= idx;
            rtag           <= tag;
            o_mem_req_addr <= {i_pc[31:4], 4'b0000};
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_req_ready) begin
            cnt   <= 2'd0;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_mem_resp_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage is never reset; the valid bits alone qualify it.
  always_ff @(posedge i_clk) begin
    if (fill_beat) begin
      data_arr[ridx][cnt] <= i_mem_resp_data;
      if (cnt == 2'd3) begin
        tag_arr[ridx] <= rtag;
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Purpose: directed + randomized bench for icache_fetch against a line-level cache model.
// Latency: checks sample on the falling edge, inputs change 1 time unit after the rising edge.
// Backpressure: the bench plays memory, stalling the request channel and gapping response beats.
module tb_icache_fetch;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_pc;
  logic         i_invalidate;
  logic [127:0] o_inst;
  logic [3:0]   o_cache_miss;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [31:0]  o_mem_req_addr;
  logic         i_mem_resp_valid;
  logic [31:0]  i_mem_resp_data;

  icache_fetch #(.LINES(16)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pc             (i_pc),
    .i_invalidate     (i_invalidate),
    .o_inst           (o_inst),
    .o_cache_miss     (o_cache_miss),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_resp_data  (i_mem_resp_data)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model: which memory line (address >> 4) each of the 16 slots holds, and its four words.
  bit          m_valid [16];
  logic [27:0] m_line  [16];
  logic [31:0] m_word  [16][4];

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic bit line_cached(input logic [31:0] pc);
    int l;
    l = int'(pc[7:4]);
    return m_valid[l] && (m_line[l] == pc[31:4]);
  endfunction

  // Slot k is the word at pc+4k, delivered only if it lies in pc's own line and that line is cached.
  function automatic logic [3:0] exp_miss(input logic [31:0] pc);
    logic [3:0]  r;
    logic [31:0] a;
    r = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      a = pc + 32'(4 * k);
      if (a[31:4] == pc[31:4] && line_cached(pc)) r[k] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_inst(input logic [31:0] pc);
    logic [127:0] r;
    logic [31:0]  a;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a = pc + 32'(4 * k);
      if (a[31:4] == pc[31:4] && line_cached(pc)) r[32*k +: 32] = m_word[int'(pc[7:4])][int'(a[3:2])];
    end
    return r;
  endfunction

  function automatic void model_flush();
    for (int l = 0; l < 16; l++) m_valid[l] = 1'b0;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic look();
    @(negedge i_clk);
  endtask

  task automatic check_lookup(input logic [31:0] pc, input string nm);
    chk({nm, "_miss"}, 128'(o_cache_miss), 128'(exp_miss(pc)));
    chk({nm, "_inst"}, o_inst, exp_inst(pc));
    chk({nm, "_reqv"}, 128'(o_mem_req_valid), 128'(1'b0));
  endtask

  // In IDLE with a missing pc: expect a full miss, then the FSM leaves for REQ.
  task automatic start_miss(input logic [31:0] pc);
    i_pc = pc;
    look();
    check_lookup(pc, "miss_lookup");
    tick();
  endtask

  // From REQ: stall the request, accept it, stream 4 beats with gaps, then check the result.
  task automatic serve(input logic [31:0] pc, input int delay, input bit inv_last, input logic [127:0] words);
    logic [31:0] line;
    line = {pc[31:4], 4'b0000};
    for (int d = 0; d < delay; d++) begin
      i_mem_req_ready  = 1'b0;
      i_mem_resp_valid = 1'($urandom_range(0, 1));
      i_mem_resp_data  = $urandom;
      i_pc             = $urandom;
      look();
      chk("req_valid_wait", 128'(o_mem_req_valid), 128'(1'b1));
      chk("req_addr_wait", 128'(o_mem_req_addr), 128'(line));
      chk("busy_miss_req", 128'(o_cache_miss), 128'(4'hF));
      tick();
    end
    i_mem_req_ready  = 1'b1;
    i_mem_resp_valid = 1'b0;
    look();
    chk("req_valid_acc", 128'(o_mem_req_valid), 128'(1'b1));
    chk("req_addr_acc", 128'(o_mem_req_addr), 128'(line));
    tick();
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        i_mem_resp_valid = 1'b0;
        i_pc             = $urandom;
        look();
        chk("fill_gap_reqv", 128'(o_mem_req_valid), 128'(1'b0));
        chk("fill_gap_miss", 128'(o_cache_miss), 128'(4'hF));
        tick();
      end
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = words[32*b +: 32];
      i_invalidate     = inv_last && (b == 3);
      if (b == 3) i_pc = pc;
      look();
      chk("fill_beat_miss", 128'(o_cache_miss), 128'(4'hF));
      tick();
    end
    i_mem_resp_valid = 1'b0;
    i_invalidate     = 1'b0;
    i_pc             = pc;
    if (inv_last) begin
      model_flush();
    end else begin
      m_valid[int'(pc[7:4])] = 1'b1;
      m_line[int'(pc[7:4])]  = pc[31:4];
      for (int b = 0; b < 4; b++) m_word[int'(pc[7:4])][b] = words[32*b +: 32];
    end
    look();
    check_lookup(pc, "post_fill");
    tick();
  endtask

  task automatic hit_pc(input logic [31:0] pc, input string nm);
    i_pc             = pc;
    i_mem_resp_valid = 1'($urandom_range(0, 1));
    i_mem_resp_data  = $urandom;
    look();
    check_lookup(pc, nm);
    tick();
    i_mem_resp_valid = 1'b0;
    look();
    chk({nm, "_noreq"}, 128'(o_mem_req_valid), 128'(1'b0));
    tick();
  endtask

  function automatic logic [127:0] rnd_words();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [31:0] pc;
    bit          inv;
    model_flush();
    i_rst            = 1'b1;
    i_pc             = 32'h0;
    i_invalidate     = 1'b0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_data  = 32'h0;
    #1;
    chk("rst_miss", 128'(o_cache_miss), 128'(4'hF));
    chk("rst_reqv", 128'(o_mem_req_valid), 128'(1'b0));
    chk("rst_addr", 128'(o_mem_req_addr), 128'(32'h0));
    chk("rst_inst", o_inst, 128'h0);
    tick();
    tick();
    i_rst = 1'b0;

    // First fill of line 0 with known words.
    start_miss(32'h0);
    serve(32'h0, 0, 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("tp_fill_inst", o_inst, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Offsets near the line end report a prefix of hits.
    i_pc = 32'h8;
    look();
    chk("tp_off8_miss", 128'(o_cache_miss), 128'(4'b1100));
    chk("tp_off8_inst", 128'(o_inst[63:0]), 128'({32'hA3, 32'hA2}));
    tick();
    hit_pc(32'h8, "off8");
    hit_pc(32'hC, "offC");

    // Request stalled for 3 cycles.
    start_miss(32'h40);
    serve(32'h40, 3, 1'b0, rnd_words());

    // Conflict eviction of line 0.
    start_miss(32'h100);
    serve(32'h100, 1, 1'b0, rnd_words());
    start_miss(32'h0);
    serve(32'h0, 0, 1'b0, rnd_words());

    // Invalidate on the last beat: line ends invalid and the same pc re-requests.
    start_miss(32'h284);
    serve(32'h284, 0, 1'b1, rnd_words());
    serve(32'h284, 2, 1'b0, rnd_words());

    // Invalidate in IDLE on a hitting pc.
    i_pc         = 32'h284;
    i_invalidate = 1'b1;
    look();
    check_lookup(32'h284, "inv_idle_same");
    tick();
    i_invalidate = 1'b0;
    model_flush();
    start_miss(32'h284);
    serve(32'h284, 0, 1'b0, rnd_words());

    // Reset in the middle of a fill.
    start_miss(32'h300);
    i_mem_req_ready = 1'b1;
    look();
    tick();
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = $urandom;
      tick();
    end
    i_mem_resp_valid = 1'b0;
    i_rst            = 1'b1;
    #1;
    chk("midrst_reqv", 128'(o_mem_req_valid), 128'(1'b0));
    chk("midrst_miss", 128'(o_cache_miss), 128'(4'hF));
    chk("midrst_addr", 128'(o_mem_req_addr), 128'(32'h0));
    chk("midrst_inst", o_inst, 128'h0);
    model_flush();
    tick();
    i_rst = 1'b0;
    start_miss(32'h300);
    serve(32'h300, 1, 1'b0, rnd_words());

    // Randomized traffic over a few tags so hits, conflicts and invalidates all occur.
    for (int it = 0; it < 60; it++) begin
      pc = {24'($urandom_range(0, 2) * 'h1357), 4'($urandom), 4'($urandom)};
      if (line_cached(pc)) begin
        if ($urandom_range(0, 7) == 0) begin
          i_pc         = pc;
          i_invalidate = 1'b1;
          look();
          check_lookup(pc, "rnd_inv");
          tick();
          i_invalidate = 1'b0;
          model_flush();
        end else begin
          hit_pc(pc, "rnd_hit");
        end
      end else begin
        inv = ($urandom_range(0, 7) == 0);
        start_miss(pc);
        serve(pc, $urandom_range(0, 2), inv, rnd_words());
        if (inv) serve(pc, 0, 1'b0, rnd_words());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
